// File: rtl/cpu_core_param.sv
// Parametrised single-issue CPU core: PC logic, decode, register file, ALU, branch unit and a stall-aware
// load/store interface. Define CPU_SHIFT_EN to add the sll/srl/sra/ror opcodes (0x0D-0x10).
`timescale 1ns/1ps

module cpu_core_param #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int PC_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic              IMEM_BUSY,
  output logic [PC_W-1:0]   PC,
  output logic              DMEM_READ,
  output logic              DMEM_WRITE,
  output logic [7:0]        DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  input  logic              DMEM_BUSY
);
  localparam int RI_W = $clog2(NREGS);

  typedef enum logic {S_EXEC, S_MEM} state_t;

  typedef enum logic [7:0] {
    OP_LOADI = 8'h00, OP_MOV = 8'h01, OP_ADD = 8'h02, OP_SUB = 8'h03,
    OP_AND   = 8'h04, OP_OR  = 8'h05, OP_J   = 8'h06, OP_BEQ = 8'h07,
    OP_BNE   = 8'h08, OP_LWD = 8'h09, OP_LWI = 8'h0A, OP_SWD = 8'h0B,
    OP_SWI   = 8'h0C, OP_SLL = 8'h0D, OP_SRL = 8'h0E, OP_SRA = 8'h0F,
    OP_ROR   = 8'h10
  } opcode_e;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [RI_W-1:0]   r_rd;

  logic [7:0]        w_opcode;
  logic [RI_W-1:0]   w_rd, w_rs1, w_rs2;
  logic [DATA_W-1:0] w_a, w_b, w_imm, w_diff, w_result;
  logic [PC_W-1:0]   w_pc_plus4, w_target, w_pc_next;
  logic              w_zero, w_we, w_is_mem, w_is_load;
  logic [7:0]        w_mem_addr;
  logic              w_exec_fire, w_mem_start, w_mem_done;
  logic              w_unused;

  assign w_opcode   = INSTRUCTION[31:24];
  assign w_rd       = INSTRUCTION[16 +: RI_W];
  assign w_rs1      = INSTRUCTION[8 +: RI_W];
  assign w_rs2      = INSTRUCTION[0 +: RI_W];
  assign w_a        = r_regs[w_rs1];
  assign w_b        = r_regs[w_rs2];
  assign w_imm      = DATA_W'($signed(INSTRUCTION[7:0]));
  assign w_diff     = w_a - w_b;
  assign w_zero     = (w_diff == '0);
  assign w_pc_plus4 = PC + PC_W'(4);
  assign w_target   = w_pc_plus4 + (PC_W'($signed(INSTRUCTION[23:16])) << 2);
  assign w_unused   = &{1'b0, INSTRUCTION};

`ifdef CPU_SHIFT_EN
  logic [4:0] w_shamt;
  logic [5:0] w_rot;
  assign w_shamt = INSTRUCTION[4:0];
  assign w_rot   = 6'(int'(w_shamt) % DATA_W);
`endif

  // Decode and execute for the instruction currently presented.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_we       = 1'b0;
    w_result   = '0;
    w_is_mem   = 1'b0;
    w_is_load  = 1'b0;
    w_mem_addr = '0;
    w_pc_next  = w_pc_plus4;
    case (w_opcode)
      OP_LOADI: begin w_we = 1'b1; w_result = w_imm;       end
      OP_MOV:   begin w_we = 1'b1; w_result = w_b;         end
      OP_ADD:   begin w_we = 1'b1; w_result = w_a + w_b;   end
      OP_SUB:   begin w_we = 1'b1; w_result = w_diff;      end
      OP_AND:   begin w_we = 1'b1; w_result = w_a & w_b;   end
      OP_OR:    begin w_we = 1'b1; w_result = w_a | w_b;   end
      OP_J:     w_pc_next = w_target;
      OP_BEQ:   if (w_zero)  w_pc_next = w_target;
      OP_BNE:   if (!w_zero) w_pc_next = w_target;
      OP_LWD:   begin w_is_mem = 1'b1; w_is_load = 1'b1; w_mem_addr = w_b[7:0];          end
      OP_LWI:   begin w_is_mem = 1'b1; w_is_load = 1'b1; w_mem_addr = INSTRUCTION[7:0];  end
      OP_SWD:   begin w_is_mem = 1'b1; w_mem_addr = w_b[7:0];                             end
      OP_SWI:   begin w_is_mem = 1'b1; w_mem_addr = INSTRUCTION[7:0];                     end
`ifdef CPU_SHIFT_EN
      OP_SLL:   begin
        w_we     = 1'b1;
        w_result = (int'(w_shamt) >= DATA_W) ? '0 : (w_a << w_shamt);
      end
      OP_SRL:   begin
        w_we     = 1'b1;
        w_result = (int'(w_shamt) >= DATA_W) ? '0 : (w_a >> w_shamt);
      end
      OP_SRA:   begin w_we = 1'b1; w_result = $unsigned($signed(w_a) >>> w_shamt); end
      OP_ROR:   begin
        w_we     = 1'b1;
        w_result = (w_a >> w_rot) | (w_a << (DATA_W - int'(w_rot)));
      end
`endif
      default: ;
    endcase
  end

  // Instruction sequencing: one cycle for ALU/branch ops, a request/complete pair for memory ops.
  always_comb begin
    w_state_nxt = r_state;
    w_exec_fire = 1'b0;
    w_mem_start = 1'b0;
    w_mem_done  = 1'b0;
    case (r_state)
      S_EXEC: if (!IMEM_BUSY) begin
        if (w_is_mem) begin
          w_mem_start = 1'b1;
          w_state_nxt = S_MEM;
        end else begin
          w_exec_fire = 1'b1;
        end
      end
      S_MEM: if (!DMEM_BUSY) begin
        w_mem_done  = 1'b1;
        w_state_nxt = S_EXEC;
      end
      default: w_state_nxt = S_EXEC;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_EXEC;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC         <= '0;
      DMEM_READ  <= 1'b0;
      DMEM_WRITE <= 1'b0;
      DMEM_ADDR  <= '0;
      DMEM_WDATA <= '0;
      r_rd       <= '0;
      // NOTE: the register file must come up zeroed, so it is built from resettable flops, not a RAM.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_exec_fire) begin
        if (w_we) r_regs[w_rd] <= w_result;
        PC <= w_pc_next;
      end
      if (w_mem_start) begin
        DMEM_READ  <= w_is_load;
        DMEM_WRITE <= !w_is_load;
        DMEM_ADDR  <= w_mem_addr;
        DMEM_WDATA <= w_a;
        r_rd       <= w_rd;
      end
      if (w_mem_done) begin
        if (DMEM_READ) r_regs[r_rd] <= DMEM_RDATA;
        DMEM_READ  <= 1'b0;
        DMEM_WRITE <= 1'b0;
        PC         <= w_pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: random program run against an instruction-level reference model,
// with a scoreboard monitor comparing the retired-PC stream and every data-memory request.
`timescale 1ns/1ps

module tb_cpu_core_param;
  localparam int DATA_W  = 8;
  localparam int NREGS   = 8;
  localparam int PC_W    = 32;
  localparam int IM_N    = 64;
  localparam int N_INSTR = 300;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [31:0]       INSTRUCTION;
  logic              IMEM_BUSY = 1'b0;
  logic [PC_W-1:0]   PC;
  logic              DMEM_READ, DMEM_WRITE;
  logic [7:0]        DMEM_ADDR;
  logic [DATA_W-1:0] DMEM_WDATA;
  logic [DATA_W-1:0] DMEM_RDATA;
  logic              DMEM_BUSY = 1'b0;

  cpu_core_param #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IMEM_BUSY(IMEM_BUSY), .PC(PC),
    .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_BUSY(DMEM_BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit                wr;
    logic [7:0]        addr;
    logic [DATA_W-1:0] wdata;
  } mem_ev_t;

  logic [31:0]       imem [IM_N];
  logic [DATA_W-1:0] dmem [256];
  logic [DATA_W-1:0] mem_m [256];
  logic [DATA_W-1:0] regs_m [NREGS];
  logic [31:0]       garbage = 32'hDEAD_BEEF;

  logic [PC_W-1:0] pc_q [$];
  mem_ev_t         mem_q [$];

  int n_checks = 0;
  int n_errors = 0;
  bit rand_en = 0;
  bit mon_en = 0;

  logic [PC_W-1:0] prev_pc = '0;
  logic [1:0]      prev_kind = 2'b00;
  logic [7:0]      prev_addr = '0;
  logic [DATA_W-1:0] prev_wdata = '0;

  assign INSTRUCTION = IMEM_BUSY ? garbage : imem[PC[7:2]];
  assign DMEM_RDATA  = DMEM_BUSY ? garbage[DATA_W-1:0] : dmem[DMEM_ADDR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Random program; branch offsets never point back at the branch itself, so every retirement moves PC.
  task automatic gen_program();
    for (int i = 0; i < IM_N; i++) begin
      int r;
      logic [7:0] op;
      logic [31:0] w;
      r = $urandom_range(0, 19);
      op = (r <= 16) ? 8'(r) : 8'($urandom_range(8'h11, 8'hFF));
      w = $urandom;
      w[31:24] = op;
      if ((op == 8'h06 || op == 8'h07 || op == 8'h08) && w[23:16] == 8'hFF) w[23:16] = 8'h01;
      imem[i] = w;
    end
  endtask

  // Instruction-level reference: executes N_INSTR instructions and queues the expected observations.
  task automatic run_model();
    logic [PC_W-1:0] pc_m, nxt;
    logic [31:0] ins;
    logic [DATA_W-1:0] a, b, t;
    int op, rd, rs1, rs2, imm, off, sh;
    mem_ev_t ev;
    pc_m = '0;
    for (int i = 0; i < NREGS; i++) regs_m[i] = '0;
    for (int s = 0; s < N_INSTR; s++) begin
      ins = imem[pc_m[7:2]];
      op  = int'(ins[31:24]);
      rd  = int'(ins[23:16]) % NREGS;
      rs1 = int'(ins[15:8]) % NREGS;
      rs2 = int'(ins[7:0]) % NREGS;
      imm = int'($signed(ins[7:0]));
      off = int'($signed(ins[23:16]));
      sh  = int'(ins[4:0]);
      a = regs_m[rs1];
      b = regs_m[rs2];
      t = a;
      nxt = pc_m + 4;
      case (op)
        0: regs_m[rd] = DATA_W'(imm);
        1: regs_m[rd] = b;
        2: regs_m[rd] = a + b;
        3: regs_m[rd] = a - b;
        4: regs_m[rd] = a & b;
        5: regs_m[rd] = a | b;
        6: nxt = pc_m + 4 + PC_W'(off * 4);
        7: if (a == b) nxt = pc_m + 4 + PC_W'(off * 4);
        8: if (a != b) nxt = pc_m + 4 + PC_W'(off * 4);
        9, 10, 11, 12: begin
          ev.addr  = (op == 9 || op == 11) ? b[7:0] : ins[7:0];
          ev.wr    = (op >= 11);
          ev.wdata = ev.wr ? a : '0;
          if (ev.wr) mem_m[ev.addr] = a;
          else       regs_m[rd] = mem_m[ev.addr];
          mem_q.push_back(ev);
        end
`ifdef CPU_SHIFT_EN
        13: begin for (int k = 0; k < sh; k++) t = {t[DATA_W-2:0], 1'b0};       regs_m[rd] = t; end
        14: begin for (int k = 0; k < sh; k++) t = {1'b0, t[DATA_W-1:1]};       regs_m[rd] = t; end
        15: begin for (int k = 0; k < sh; k++) t = {t[DATA_W-1], t[DATA_W-1:1]}; regs_m[rd] = t; end
        16: begin for (int k = 0; k < sh % DATA_W; k++) t = {t[0], t[DATA_W-1:1]}; regs_m[rd] = t; end
`endif
        default: ;
      endcase
      pc_q.push_back(nxt);
      pc_m = nxt;
    end
  endtask

  // Memory/IMEM environment: random busy patterns, store commit on the edge the DUT completes it.
  initial begin
    forever begin
      @(negedge CLK);
      if (rand_en) begin
        IMEM_BUSY = ($urandom_range(0, 3) == 0);
        DMEM_BUSY = ($urandom_range(0, 2) == 0);
        garbage   = $urandom;
      end
      if (DMEM_WRITE && !DMEM_BUSY) dmem[DMEM_ADDR] = DMEM_WDATA;
    end
  end

  // Scoreboard monitor: pops on every PC change and every new memory request.
  initial begin
    logic [PC_W-1:0] exp_pc;
    mem_ev_t e;
    logic [1:0] kind;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        kind = {DMEM_READ, DMEM_WRITE};
        if (PC !== prev_pc) begin
          if (pc_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL pc_extra: got %0h expected no further retirement", PC);
          end else begin
            exp_pc = pc_q.pop_front();
            check("pc_seq", 64'(PC), 64'(exp_pc));
          end
          check("req_clear_at_retire", 64'(kind), 64'(2'b00));
          if (pc_q.size() == 0) mon_en = 0;
        end
        if (kind != 2'b00 && prev_kind == 2'b00) begin
          if (mem_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL mem_extra: got request kind %0h addr %0h expected none", kind, DMEM_ADDR);
          end else begin
            e = mem_q.pop_front();
            check("mem_kind", 64'(kind), e.wr ? 64'(2'b01) : 64'(2'b10));
            check("mem_addr", 64'(DMEM_ADDR), 64'(e.addr));
            if (e.wr) check("mem_wdata", 64'(DMEM_WDATA), 64'(e.wdata));
          end
        end else if (kind != 2'b00) begin
          check("req_hold_kind", 64'(kind), 64'(prev_kind));
          check("req_hold_addr", 64'(DMEM_ADDR), 64'(prev_addr));
          check("req_hold_wdata", 64'(DMEM_WDATA), 64'(prev_wdata));
        end
        prev_pc    = PC;
        prev_kind  = kind;
        prev_addr  = DMEM_ADDR;
        prev_wdata = DMEM_WDATA;
      end
    end
  end

  initial begin
    int c;
    for (int i = 0; i < 256; i++) begin
      dmem[i]  = DATA_W'($urandom);
      mem_m[i] = dmem[i];
    end
    gen_program();
    run_model();

    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_pc", 64'(PC), 64'(0));
    check("reset_read", 64'(DMEM_READ), 64'(0));
    check("reset_write", 64'(DMEM_WRITE), 64'(0));
    check("reset_addr", 64'(DMEM_ADDR), 64'(0));
    check("reset_wdata", 64'(DMEM_WDATA), 64'(0));

    @(negedge CLK);
    prev_pc = '0;
    prev_kind = 2'b00;
    RESET = 1'b0;
    mon_en = 1;
    rand_en = 1;

    c = 0;
    while (pc_q.size() != 0 && c < 20000) begin
      @(posedge CLK);
      c++;
    end
    if (pc_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL run_timeout: got %0d retirements pending expected 0", pc_q.size());
    end
    mon_en = 0;
    check("mem_q_drained", 64'(mem_q.size()), 64'(0));

    // Reset arriving while a load is stalled must abort it in the same edge.
    @(negedge CLK);
    rand_en = 0;
    IMEM_BUSY = 1'b0;
    DMEM_BUSY = 1'b1;
    RESET = 1'b1;
    imem[0] = {8'h0A, 8'h04, 8'h00, 8'h20};
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("abort_setup_read", 64'(DMEM_READ), 64'(1));
    check("abort_setup_addr", 64'(DMEM_ADDR), 64'(8'h20));
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_read", 64'(DMEM_READ), 64'(0));
    check("abort_pc", 64'(PC), 64'(0));
    @(negedge CLK);
    RESET = 1'b0;
    DMEM_BUSY = 1'b0;
    imem[0] = {8'h0C, 8'h00, 8'h04, 8'h30};
    @(posedge CLK);
    #1;
    check("after_abort_write", 64'(DMEM_WRITE), 64'(1));
    check("after_abort_addr", 64'(DMEM_ADDR), 64'(8'h30));
    check("after_abort_r4", 64'(DMEM_WDATA), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
